// File: rtl/mul_seq_if.sv
// mul_seq_if: producer handshake, multiplier bus and status of the operand sequencer
interface mul_seq_if #(parameter int W = 16, parameter int CW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          mul_start;
  logic [W-1:0]  mul_data;
  logic          mul_done;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] jobs_done;
  modport slave (
    input  in_valid, in_a, in_b, mul_done,
    output in_ready, mul_start, mul_data, busy, timeout_err, jobs_done
  );
  modport master (
    output in_valid, in_a, in_b, mul_done,
    input  in_ready, mul_start, mul_data, busy, timeout_err, jobs_done
  );
endinterface

// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer: buffers (A,B) pairs and replays them onto the repeated-addition multiplier bus
module mul_operand_sequencer #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023,
  parameter int CW      = 8
) (
  input logic     clk,
  input logic     rst_n,
  mul_seq_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, START, LOAD_A, LOAD_B, WAIT} state_t;
  state_t         state, state_n;
  logic [2*W-1:0] mem [DEPTH];
  logic [2*W-1:0] work;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_n;
  logic [15:0]    wd_cnt;
  logic           armed, push, pop, done_ok, expire;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = count != '0 ? START : IDLE;
      START:   state_n = LOAD_A;
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = WAIT;
      WAIT:    state_n = done_ok || expire ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // armed blocks a done level left high by the previous job from counting as completion
  always_comb begin
    push    = s.in_valid && s.in_ready;
    pop     = state == IDLE && count != '0;
    done_ok = state == WAIT && armed && s.mul_done;
    expire  = state == WAIT && !done_ok && wd_cnt == 16'(TIMEOUT - 1);
    count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // outputs are registered from next-state so each bus value spans its whole state cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      work          <= '0;
      wd_cnt        <= '0;
      armed         <= 1'b0;
      s.in_ready    <= 1'b0;
      s.mul_start   <= 1'b0;
      s.mul_data    <= '0;
      s.busy        <= 1'b0;
      s.timeout_err <= 1'b0;
      s.jobs_done   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        work   <= mem[rd_ptr];
      end
      count         <= count_n;
      wd_cnt        <= state == WAIT ? wd_cnt + 1'b1 : '0;
      armed         <= state == WAIT && (armed || !s.mul_done);
      s.in_ready    <= count_n != (AW+1)'(DEPTH);
      s.mul_start   <= state_n == START;
      s.mul_data    <= state_n == LOAD_A ? work[2*W-1:W] : state_n == LOAD_B ? work[W-1:0] : '0;
      s.busy        <= state != IDLE || count != '0;
      s.timeout_err <= s.timeout_err || expire;
      if (done_ok) s.jobs_done <= s.jobs_done + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {s.in_a, s.in_b};
endmodule
